// File: rtl/controlador_cubos.sv
// FallingCubes game sequencer: spawns and advances cubes once per frame,
// judges them against the basket, keeps score/lives and paints the cubes.
module controlador_cubos #(
   parameter int NUM_CUBOS         = 4,
   parameter int TAMANIO_CUBO      = 32,
   parameter int TAMANIO_CANASTA   = 96,
   parameter int LINEA_CAPTURA     = 416,
   parameter int VELOCIDAD         = 2,
   parameter int PERIODO_APARICION = 60,
   parameter int VIDAS_INICIALES   = 3
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic [9:0] pos_x_canasta,
   output logic       pintar_cubo,
   output logic [7:0] puntaje,
   output logic [1:0] vidas,
   output logic [1:0] estado,
   output logic       cubo_atrapado
);

   typedef enum logic [1:0] {E_ESPERA = 2'd0, E_JUEGO = 2'd1, E_FIN = 2'd2} estado_t;

   localparam int            CW       = (PERIODO_APARICION > 1) ? $clog2(PERIODO_APARICION) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(PERIODO_APARICION - 1);
   localparam logic [10:0]   L_CUBO   = 11'(TAMANIO_CUBO);
   localparam logic [10:0]   L_CAN    = 11'(TAMANIO_CANASTA);
   localparam logic [10:0]   L_LINEA  = 11'(LINEA_CAPTURA);
   localparam logic [10:0]   L_VEL    = 11'(VELOCIDAD);
   localparam logic [1:0]    L_VIDAS  = 2'(VIDAS_INICIALES);

   function automatic logic [7:0] sat_suma(input logic [7:0] a, input logic [3:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {5'b0, b};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   function automatic logic [1:0] sat_resta(input logic [1:0] a, input logic [3:0] b);
      logic [3:0] d;
      d = {2'b00, a} - b;
      return ({2'b00, a} >= b) ? d[1:0] : 2'd0;
   endfunction

   estado_t                r_estado;
   logic [7:0]             r_puntaje;
   logic [1:0]             r_vidas;
   logic                   r_atrapado;
   logic [NUM_CUBOS-1:0]   r_act;
   logic [9:0]             r_x [NUM_CUBOS];
   logic [9:0]             r_y [NUM_CUBOS];
   logic [CW-1:0]          r_cnt;
   logic [9:0]             r_lfsr;
   logic                   r_raw_q;

   logic                         w_raw;
   logic                         w_tick;
   logic [NUM_CUBOS-1:0][10:0]   w_yn;
   logic [NUM_CUBOS-1:0]         w_juzga;
   logic [NUM_CUBOS-1:0]         w_sel;
   logic                         w_libre;
   logic [3:0]                   w_atrapes;
   logic [3:0]                   w_fallos;
   logic [1:0]                   w_vidas_n;
   logic [9:0]                   w_x_nuevo;
   logic                         w_pinta;

   // One tick per frame even when the pixel counters dwell on the trigger point
   assign w_raw     = (pixel_y == 10'd481) && (pixel_x == 10'd0);
   assign w_tick    = w_raw & ~r_raw_q;
   assign w_x_nuevo = {1'b0, r_lfsr[8:0]} + 10'd64;
   assign w_vidas_n = sat_resta(r_vidas, w_fallos);

   // Free slot selection uses the pre-tick mask, so a slot judged now is not reused now
   always_comb begin
      w_atrapes = '0;
      w_fallos  = '0;
      w_sel     = '0;
      w_libre   = 1'b0;
      w_yn      = '0;
      w_juzga   = '0;
      for (int i = 0; i < NUM_CUBOS; i++) begin
         w_yn[i]    = {1'b0, r_y[i]} + L_VEL;
         w_juzga[i] = r_act[i] && ((w_yn[i] + L_CUBO) >= L_LINEA);
         if (w_juzga[i]) begin
            if ((({1'b0, r_x[i]} + L_CUBO) > {1'b0, pos_x_canasta}) &&
                ({1'b0, r_x[i]} < ({1'b0, pos_x_canasta} + L_CAN)))
               w_atrapes = w_atrapes + 4'd1;
            else
               w_fallos = w_fallos + 4'd1;
         end
         if (!r_act[i] && !w_libre) begin
            w_sel[i] = 1'b1;
            w_libre  = 1'b1;
         end
      end
   end

   always_comb begin
      w_pinta = 1'b0;
      for (int i = 0; i < NUM_CUBOS; i++) begin
         if (r_act[i] &&
             ({1'b0, pixel_x} >= {1'b0, r_x[i]}) && ({1'b0, pixel_x} < ({1'b0, r_x[i]} + L_CUBO)) &&
             ({1'b0, pixel_y} >= {1'b0, r_y[i]}) && ({1'b0, pixel_y} < ({1'b0, r_y[i]} + L_CUBO)))
            w_pinta = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_estado   <= E_ESPERA;
         r_puntaje  <= '0;
         r_vidas    <= L_VIDAS;
         r_atrapado <= 1'b0;
         r_act      <= '0;
         r_cnt      <= '0;
         r_lfsr     <= 10'h1A5;
         r_raw_q    <= 1'b0;
      end else begin
         r_lfsr     <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
         r_raw_q    <= w_raw;
         r_atrapado <= 1'b0;
         case (r_estado)
            E_ESPERA, E_FIN: begin
               if (start) begin
                  r_estado  <= E_JUEGO;
                  r_puntaje <= '0;
                  r_vidas   <= L_VIDAS;
                  r_act     <= '0;
                  r_cnt     <= '0;
               end
            end
            E_JUEGO: begin
               if (w_tick) begin
                  for (int i = 0; i < NUM_CUBOS; i++) begin
                     if (w_juzga[i])
                        r_act[i] <= 1'b0;
                     else if (r_act[i])
                        r_y[i] <= w_yn[i][9:0];
                  end
                  if (r_cnt < CNT_MAX) begin
                     r_cnt <= r_cnt + CW'(1);
                  end else if (w_libre) begin
                     r_cnt <= '0;
                     for (int i = 0; i < NUM_CUBOS; i++) begin
                        if (w_sel[i]) begin
                           r_act[i] <= 1'b1;
                           r_x[i]   <= w_x_nuevo;
                           r_y[i]   <= '0;
                        end
                     end
                  end
                  r_puntaje  <= sat_suma(r_puntaje, w_atrapes);
                  r_vidas    <= w_vidas_n;
                  r_atrapado <= (w_atrapes != 4'd0);
                  if (w_vidas_n == 2'd0)
                     r_estado <= E_FIN;
               end
            end
            default: r_estado <= E_ESPERA;
         endcase
      end
   end

   assign pintar_cubo   = w_pinta && (r_estado != E_ESPERA);
   assign puntaje       = r_puntaje;
   assign vidas         = r_vidas;
   assign estado        = r_estado;
   assign cubo_atrapado = r_atrapado;

endmodule

// File: tb/tb_controlador_cubos.sv
// Bench for controlador_cubos: two instances (spawn period 60 and 1) driven with
// randomized frames and compared every clock against a slot-array reference model.
module tb_controlador_cubos;

   localparam int TC = 32, TCAN = 96, LINEA = 416, VEL = 2, VI = 3, NC = 4;

   logic       clk = 1'b0;
   logic       reset, start;
   logic [9:0] pixel_x, pixel_y, pos;
   logic       pinta_a, atr_a, pinta_b, atr_b;
   logic [7:0] pts_a, pts_b;
   logic [1:0] vid_a, vid_b, est_a, est_b;

   always #5 clk = ~clk;

   controlador_cubos dut_a (
      .clk(clk), .reset(reset), .start(start), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .pos_x_canasta(pos), .pintar_cubo(pinta_a), .puntaje(pts_a), .vidas(vid_a),
      .estado(est_a), .cubo_atrapado(atr_a));

   controlador_cubos #(.PERIODO_APARICION(1)) dut_b (
      .clk(clk), .reset(reset), .start(start), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .pos_x_canasta(pos), .pintar_cubo(pinta_b), .puntaje(pts_b), .vidas(vid_b),
      .estado(est_b), .cubo_atrapado(atr_b));

   int n_chk = 0, n_err = 0;

   // Reference model: index 0 mirrors dut_a, index 1 mirrors dut_b
   bit m_act [2][NC];
   int m_x   [2][NC];
   int m_y   [2][NC];
   int m_cnt [2];
   int m_pts [2];
   int m_vid [2];
   int m_est [2];
   bit m_atr [2];
   int m_lfsr;
   bit m_rawq;
   bit last_atr_a;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_lfsr = 'h1A5;
      m_rawq = 1'b0;
      for (int k = 0; k < 2; k++) begin
         for (int s = 0; s < NC; s++) m_act[k][s] = 1'b0;
         m_cnt[k] = 0; m_pts[k] = 0; m_vid[k] = VI; m_est[k] = 0; m_atr[k] = 1'b0;
      end
   endtask

   task automatic model_step();
      bit raw, tick;
      int sx, p;
      raw  = (pixel_y == 481) && (pixel_x == 0);
      tick = raw && !m_rawq;
      sx   = (m_lfsr % 512) + 64;
      p    = int'(pos);
      for (int k = 0; k < 2; k++) begin
         int c, m, fr, per;
         per = (k == 0) ? 60 : 1;
         m_atr[k] = 1'b0;
         if (m_est[k] != 1) begin
            if (start) begin
               m_est[k] = 1; m_pts[k] = 0; m_vid[k] = VI; m_cnt[k] = 0;
               for (int s = 0; s < NC; s++) m_act[k][s] = 1'b0;
            end
         end else if (tick) begin
            c = 0; m = 0; fr = -1;
            for (int s = 0; s < NC; s++)
               if (!m_act[k][s] && fr < 0) fr = s;
            for (int s = 0; s < NC; s++) begin
               if (m_act[k][s]) begin
                  if (m_y[k][s] + VEL + TC >= LINEA) begin
                     m_act[k][s] = 1'b0;
                     if (m_x[k][s] + TC > p && m_x[k][s] < p + TCAN) c++;
                     else m++;
                  end else begin
                     m_y[k][s] += VEL;
                  end
               end
            end
            if (m_cnt[k] < per - 1) begin
               m_cnt[k]++;
            end else if (fr >= 0) begin
               m_act[k][fr] = 1'b1; m_x[k][fr] = sx; m_y[k][fr] = 0; m_cnt[k] = 0;
            end
            m_pts[k] = (m_pts[k] + c > 255) ? 255 : m_pts[k] + c;
            m_vid[k] = (m_vid[k] - m < 0) ? 0 : m_vid[k] - m;
            m_atr[k] = (c > 0);
            if (m_vid[k] == 0) m_est[k] = 2;
         end
      end
      m_lfsr = ((m_lfsr << 1) & 'h3FF) | (((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1);
      m_rawq = raw;
   endtask

   function automatic bit m_paint(input int k);
      int px, py;
      px = int'(pixel_x);
      py = int'(pixel_y);
      if (m_est[k] == 0) return 1'b0;
      for (int s = 0; s < NC; s++)
         if (m_act[k][s] && px >= m_x[k][s] && px < m_x[k][s] + TC &&
             py >= m_y[k][s] && py < m_y[k][s] + TC)
            return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_all();
      chk("A_estado",  int'(est_a),  m_est[0]);
      chk("A_puntaje", int'(pts_a),  m_pts[0]);
      chk("A_vidas",   int'(vid_a),  m_vid[0]);
      chk("A_atrap",   int'(atr_a),  int'(m_atr[0]));
      chk("A_pinta",   int'(pinta_a), int'(m_paint(0)));
      chk("B_estado",  int'(est_b),  m_est[1]);
      chk("B_puntaje", int'(pts_b),  m_pts[1]);
      chk("B_vidas",   int'(vid_b),  m_vid[1]);
      chk("B_atrap",   int'(atr_b),  int'(m_atr[1]));
      chk("B_pinta",   int'(pinta_b), int'(m_paint(1)));
   endtask

   task automatic step_clk();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   // Non-tick pixel, biased onto a cube half of the time so painting is exercised
   task automatic drive_gap();
      int k, s, v;
      k = int'($urandom_range(0, 1));
      s = int'($urandom_range(0, NC - 1));
      if ($urandom_range(0, 1) == 1 && m_act[k][s]) begin
         v = m_x[k][s] + int'($urandom_range(0, TC + 5)) - 3;
         pixel_x = 10'((v < 0) ? 0 : v);
         v = m_y[k][s] + int'($urandom_range(0, TC + 5)) - 3;
         pixel_y = 10'((v < 0) ? 0 : v);
      end else begin
         pixel_x = 10'($urandom_range(0, 639));
         pixel_y = 10'($urandom_range(0, 479));
      end
   endtask

   task automatic tick_frame(input int hold);
      pixel_x = 10'd0;
      pixel_y = 10'd481;
      for (int h = 0; h < hold; h++) begin
         step_clk();
         if (h == 0) last_atr_a = atr_a;
      end
      drive_gap();
      step_clk();
   endtask

   initial begin
      int off [6];
      bit cat [6];
      int pi, e_pts, e_vid, budget, js, p;
      off = '{0, 32, 31, -96, -95, 32};
      cat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

      reset = 1'b0; start = 1'b0; pos = '0; pixel_x = '0; pixel_y = '0;
      model_reset();
      repeat (2) begin
         @(negedge clk);
         check_all();
      end
      chk("rst_estado", int'(est_a), 0);
      chk("rst_vidas", int'(vid_a), 3);
      chk("rst_puntaje", int'(pts_a), 0);
      chk("rst_atrap", int'(atr_a), 0);

      reset = 1'b1;
      repeat (2) begin drive_gap(); step_clk(); end
      start = 1'b1;
      step_clk();
      start = 1'b0;
      chk("start_estado", int'(est_a), 1);
      chk("start_vidas", int'(vid_a), 3);
      chk("start_puntaje", int'(pts_a), 0);

      // Scripted judgements on dut_a: catch, both overlap boundaries, then three misses
      pi = 0; e_pts = 0; e_vid = 3; budget = 0;
      while (pi < 6 && budget < 1200) begin
         js = -1;
         for (int s = 0; s < NC; s++)
            if (m_act[0][s] && m_y[0][s] + VEL + TC >= LINEA) js = s;
         if (js >= 0) begin
            p = m_x[0][js] + off[pi];
            if (p < 0) p = cat[pi] ? m_x[0][js] : m_x[0][js] + TC;
            pos = 10'(p);
         end else begin
            pos = 10'($urandom_range(0, 1023));
         end
         tick_frame(1);
         budget++;
         if (budget == 59) chk("pre_spawn_pinta", int'(pinta_a), 0);
         if (budget == 60) begin
            pixel_x = 10'(m_x[0][0]);
            pixel_y = 10'd0;
            #1;
            chk("spawn_pinta", int'(pinta_a), 1);
         end
         if (js >= 0) begin
            e_pts += int'(cat[pi]);
            e_vid -= int'(!cat[pi]);
            chk("plan_puntaje", int'(pts_a), e_pts);
            chk("plan_vidas", int'(vid_a), e_vid);
            chk("plan_pulso", int'(last_atr_a), int'(cat[pi]));
            pi++;
         end
      end
      chk("plan_completo", pi, 6);
      chk("fin_estado", int'(est_a), 2);

      repeat (20) begin
         pos = 10'($urandom_range(0, 1023));
         tick_frame(1);
      end
      chk("fin_puntaje", int'(pts_a), 3);
      chk("fin_vidas", int'(vid_a), 0);
      chk("fin_estado2", int'(est_a), 2);

      start = 1'b1;
      step_clk();
      start = 1'b0;
      chk("restart_estado", int'(est_a), 1);
      chk("restart_vidas", int'(vid_a), 3);
      chk("restart_puntaje", int'(pts_a), 0);

      tick_frame(5);
      tick_frame(3);
      tick_frame(1);

      repeat (2500) begin
         pos = 10'($urandom_range(0, 1023));
         if ($urandom_range(0, 39) == 0) start = 1'b1;
         tick_frame(int'($urandom_range(1, 4)));
         start = 1'b0;
      end

      start = 1'b1;
      step_clk();
      start = 1'b0;
      repeat (100) begin
         pos = 10'($urandom_range(0, 1023));
         tick_frame(1);
      end
      #2 reset = 1'b0;
      model_reset();
      #1;
      chk("arst_estado", int'(est_a), 0);
      chk("arst_vidas", int'(vid_a), 3);
      chk("arst_puntaje", int'(pts_a), 0);
      chk("arst_pinta_b", int'(pinta_b), 0);
      chk("arst_estado_b", int'(est_b), 0);
      @(negedge clk);
      check_all();
      reset = 1'b1;
      repeat (5) begin drive_gap(); step_clk(); end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
